axil_mem_master: RTL
====================

// Module: axil_mem_master
// PURPOSE
//  Parametrised AXI4-Lite master load/store unit for the core datapath; next generation of the memory interface.
//  Accepts one load/fetch/store request at a time and generates byte strobes and lane shifting for any data width.
//  Returns sign/zero-extended read data and reports errors: misaligned, SLVERR/DECERR, or timeout.
//  Sits between the core FSM/register file and the system AXI4-Lite interconnect.
// PARAMETERS
//  ADDR_W       32    address width
//  DATA_W       32    bus data width, 32 or 64; NB=DATA_W/8 byte lanes
//  TIMEOUT_CYC  1024  max cycles waiting in any bus state; 0 = timeout disabled
// PORTS
//  clk         in   1        clock
//  rst         in   1        synchronous reset, active-high
//  req_valid   in   1        request strobe, sampled only when req_ready=1
//  req_ready   out  1        high only in IDLE
//  req_we      in   1        1=store, 0=load
//  req_fetch   in   1        instruction fetch; drives ARprot=3'b100 (data accesses: 3'b000)
//  req_addr    in   ADDR_W   byte address
//  req_size    in   2        00 byte, 01 half, 10 word, 11 dword (legal only if DATA_W=64)
//  req_signed  in   1        sign-extend load result
//  req_wdata   in   DATA_W   store data, LSB-justified
//  resp_valid  out  1        one-cycle completion pulse, no backpressure
//  resp_rdata  out  DATA_W   extended load data; 0 for stores and errors
//  resp_err    out  2        00 ok, 01 misaligned, 10 bus error, 11 timeout
//  halted      out  1        sticky after timeout until rst
//  AWaddr/AWvalid/AWready/AWprot, Wdata/Wstrb/Wvalid/Wready, Bresp/Bvalid/Bready,
//  ARaddr/ARvalid/ARready/ARprot, Rdata/Rresp/Rvalid/Rready: standard AXI4-Lite, widths ADDR_W/DATA_W/NB/2/3
// BEHAVIOUR
//  - Reset: state=IDLE. All *valid, *ready (except req_ready=1), resp_*, halted, Wstrb, addr/data regs = 0.
//  - All AXI outputs are registered. Request fields are captured on accept (req_valid & req_ready).
//  - Alignment: misaligned when addr[log2(1<<size)-1:0]!=0, or size=11 with DATA_W=32.
//    -> no bus traffic; next cycle resp_valid=1, err=01.
//  - Bus address = addr with low log2(NB) bits cleared. off = addr[log2(NB)-1:0].
//  - Wstrb = ((1<<(1<<size))-1) << off. Wdata = req_wdata << 8*off.
//  - Load data = (Rdata >> 8*off) truncated to the size, then sign/zero-extended to DATA_W.
//  - FSM states: IDLE, RD_A, RD_D, WR_AW, WR_B, RESP, HALT.
//    - IDLE -> RD_A: on accept of a load. ARvalid=1.
//    - RD_A -> RD_D: on ARready. ARvalid=0, Rready=1.
//    - RD_D -> RESP: on Rvalid. Capture Rdata/Rresp; Rready=0.
//    - IDLE -> WR_AW: on accept of a store. AWvalid=Wvalid=1.
//      AW and W are tracked by independent done flags; each valid drops the cycle after its own ready.
//      Both channels may complete in the same cycle or in either order.
//    - WR_AW -> WR_B: when both flags are set. Bready=1.
//    - WR_B -> RESP: on Bvalid. Bready=0.
//    - RESP: resp_valid=1 for exactly one cycle, then -> IDLE.
//      err=10 if captured Rresp/Bresp[1]=1, in which case rdata=0.
//  - Minimum latency (ready/valid returned immediately): accept at cycle 0 -> resp_valid at cycle 3, for load and store.
//  - Timeout: a counter clears on every state change.
//    In RD_A/RD_D/WR_AW/WR_B, count==TIMEOUT_CYC-1 -> one-cycle resp err=11, then HALT.
//    HALT: all AXI valids/readies=0, req_ready=0, halted=1, exited only by rst.
//  - rst mid-transaction: outputs return to reset values the next edge; the outstanding transaction is abandoned.
//  - req_valid while not in IDLE is ignored. AXI readies asserted outside the matching state are ignored.
// STRUCTURE
//  - Package axil_mem_pkg: size encodings, err codes (ERR_OK/ERR_MISALIGN/ERR_BUS/ERR_TIMEOUT), FSM state enum, PROT_FETCH/PROT_DATA.
//  - Sub-module axil_lane_align: combinational misalign check, strobe/wdata shift, rdata shift+extend; parametrised by DATA_W.
//  - Top: FSM, channel done flags, timeout counter, output registers.
// TESTING
//  1. LW 0x100 (DATA_W=32), slave returns Rdata=0xDEADBEEF with 0 wait states
//     -> ARaddr=0x100, ARprot=000, resp at cycle 3, rdata=0xDEADBEEF, err=00.
//  2. LB signed 0x103, Rdata=0x80112233
//     -> rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
//  3. SH 0x102, wdata=0x0000ABCD; Wready 4 cycles after AWready
//     -> AWaddr=0x100, Wstrb=1100, Wdata=0xABCD0000, single resp err=00.
//  4. LW 0x102 -> no ARvalid, resp next cycle, err=01. SW with Bresp=2'b10 -> err=10.
//  5. TIMEOUT_CYC=16, ARready held low -> resp err=11 at 16 cycles after ARvalid,
//     halted=1, ARvalid=0, req_ready=0 until rst.
//  6. DATA_W=64, SD 0x8 -> Wstrb=0xFF; LW 0xC with Rdata=0x11223344_55667788 -> 0x11223344.
//     Fetch request -> ARprot=100.

Source files
------------

// File: rtl/axil_mem_pkg.sv
// Shared encodings for the AXI4-Lite load/store unit: access sizes, response
// codes, protection attributes and the controller state set.
package axil_mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_BUS      = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam logic [2:0] PROT_FETCH = 3'b100;
  localparam logic [2:0] PROT_DATA  = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_D,
    ST_WR_AW,
    ST_WR_B,
    ST_RESP,
    ST_HALT
  } state_e;

  // Byte-enable pattern of an access before it is moved to its lane.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 8'h01;
      SZ_HALF: return 8'h03;
      SZ_WORD: return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/axil_lane_align.sv
// Byte-lane steering for the load/store unit: alignment check, store strobe and
// data placement, and load data extraction with sign/zero extension.
module axil_lane_align
  import axil_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB    = DATA_W / 8,
  localparam int LGNB  = $clog2(NB)
) (
  input  logic [2:0]        st_lo,
  input  logic [1:0]        st_size,
  input  logic [DATA_W-1:0] st_wdata,
  output logic              st_misalign,
  output logic [NB-1:0]     st_strb,
  output logic [DATA_W-1:0] st_wdata_sh,
  input  logic [LGNB-1:0]   ld_off,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_data
);

  logic [LGNB-1:0]   st_off;
  logic [DATA_W-1:0] ld_shifted;

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                               input logic [1:0]        sz,
                                               input logic              sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b = v[7:0];
    h = v[15:0];
    w = v[31:0];
    case (sz)
      SZ_BYTE: return sgn ? DATA_W'(b) : DATA_W'(v[7:0]);
      SZ_HALF: return sgn ? DATA_W'(h) : DATA_W'(v[15:0]);
      SZ_WORD: return sgn ? DATA_W'(w) : DATA_W'(v[31:0]);
      default: return v;
    endcase
  endfunction

  // A dword access can never be aligned on a bus narrower than 64 bits.
  always_comb begin
    st_misalign = 1'b0;
    case (st_size)
      SZ_BYTE: st_misalign = 1'b0;
      SZ_HALF: st_misalign = st_lo[0];
      SZ_WORD: st_misalign = |st_lo[1:0];
      default: st_misalign = (DATA_W < 64) || (|st_lo);
    endcase
  end

  assign st_off      = st_lo[LGNB-1:0];
  assign st_strb     = NB'(size_mask(st_size)) << st_off;
  assign st_wdata_sh = st_wdata << {st_off, 3'b000};

  assign ld_shifted  = ld_rdata >> {ld_off, 3'b000};
  assign ld_data     = extend(ld_shifted, ld_size, ld_signed);

endmodule

// File: rtl/axil_mem_master.sv
// AXI4-Lite master load/store unit: one outstanding request, registered AXI
// outputs, per-state timeout that parks the unit in HALT until reset.
module axil_mem_master
  import axil_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024,
  localparam int NB         = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_fetch,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_err,
  output logic              halted,
  output logic [ADDR_W-1:0] AWaddr,
  output logic              AWvalid,
  input  logic              AWready,
  output logic [2:0]        AWprot,
  output logic [DATA_W-1:0] Wdata,
  output logic [NB-1:0]     Wstrb,
  output logic              Wvalid,
  input  logic              Wready,
  input  logic [1:0]        Bresp,
  input  logic              Bvalid,
  output logic              Bready,
  output logic [ADDR_W-1:0] ARaddr,
  output logic              ARvalid,
  input  logic              ARready,
  output logic [2:0]        ARprot,
  input  logic [DATA_W-1:0] Rdata,
  input  logic [1:0]        Rresp,
  input  logic              Rvalid,
  output logic              Rready
);

  localparam int          LGNB     = $clog2(NB);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

  state_e            state, state_nx;
  logic              aw_done, w_done, aw_done_nx, w_done_nx;
  logic              tmo_flag, tmo_flag_nx;
  logic [31:0]       tmo_cnt;
  logic [LGNB-1:0]   ld_off;
  logic [1:0]        ld_size;
  logic              ld_signed;
  logic [1:0]        err_nx;
  logic [DATA_W-1:0] rdata_nx;
  logic              accept, misalign, bus_state, tmo_hit;
  logic [NB-1:0]     st_strb;
  logic [DATA_W-1:0] st_wdata_sh, ld_data;
  logic [2:0]        prot_sel;
  logic              unused_resp_lsb;

  axil_lane_align #(.DATA_W(DATA_W)) u_align (
    .st_lo       (req_addr[2:0]),
    .st_size     (req_size),
    .st_wdata    (req_wdata),
    .st_misalign (misalign),
    .st_strb     (st_strb),
    .st_wdata_sh (st_wdata_sh),
    .ld_off      (ld_off),
    .ld_size     (ld_size),
    .ld_signed   (ld_signed),
    .ld_rdata    (Rdata),
    .ld_data     (ld_data)
  );

  // Only the error bit of a response matters; OKAY vs EXOKAY is irrelevant here.
  assign unused_resp_lsb = ^{Rresp[0], Bresp[0]};

  assign accept    = req_valid & req_ready;
  assign prot_sel  = req_fetch ? PROT_FETCH : PROT_DATA;
  assign bus_state = (state == ST_RD_A) || (state == ST_RD_D) ||
                     (state == ST_WR_AW) || (state == ST_WR_B);
  assign tmo_hit   = (TIMEOUT_CYC != 0) && bus_state && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nx    = state;
    aw_done_nx  = aw_done;
    w_done_nx   = w_done;
    tmo_flag_nx = tmo_flag;
    err_nx      = ERR_OK;
    rdata_nx    = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (misalign) begin
            state_nx = ST_RESP;
            err_nx   = ERR_MISALIGN;
          end else if (req_we) begin
            state_nx   = ST_WR_AW;
            aw_done_nx = 1'b0;
            w_done_nx  = 1'b0;
          end else begin
            state_nx = ST_RD_A;
          end
        end
      end
      ST_RD_A: begin
        if (ARvalid && ARready) begin
          state_nx = ST_RD_D;
        end else if (tmo_hit) begin
          state_nx    = ST_RESP;
          err_nx      = ERR_TIMEOUT;
          tmo_flag_nx = 1'b1;
        end
      end
      ST_RD_D: begin
        if (Rvalid && Rready) begin
          state_nx = ST_RESP;
          err_nx   = Rresp[1] ? ERR_BUS : ERR_OK;
          rdata_nx = Rresp[1] ? '0 : ld_data;
        end else if (tmo_hit) begin
          state_nx    = ST_RESP;
          err_nx      = ERR_TIMEOUT;
          tmo_flag_nx = 1'b1;
        end
      end
      ST_WR_AW: begin
        // Address and data channels complete independently, in any order.
        aw_done_nx = aw_done | (AWvalid & AWready);
        w_done_nx  = w_done | (Wvalid & Wready);
        if (aw_done_nx && w_done_nx) begin
          state_nx = ST_WR_B;
        end else if (tmo_hit) begin
          state_nx    = ST_RESP;
          err_nx      = ERR_TIMEOUT;
          tmo_flag_nx = 1'b1;
        end
      end
      ST_WR_B: begin
        if (Bvalid && Bready) begin
          state_nx = ST_RESP;
          err_nx   = Bresp[1] ? ERR_BUS : ERR_OK;
        end else if (tmo_hit) begin
          state_nx    = ST_RESP;
          err_nx      = ERR_TIMEOUT;
          tmo_flag_nx = 1'b1;
        end
      end
      ST_RESP: state_nx = tmo_flag ? ST_HALT : ST_IDLE;
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Every output is a register loaded from the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      tmo_flag   <= 1'b0;
      tmo_cnt    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= ERR_OK;
      halted     <= 1'b0;
      AWaddr     <= '0;
      AWvalid    <= 1'b0;
      AWprot     <= PROT_DATA;
      Wdata      <= '0;
      Wstrb      <= '0;
      Wvalid     <= 1'b0;
      Bready     <= 1'b0;
      ARaddr     <= '0;
      ARvalid    <= 1'b0;
      ARprot     <= PROT_DATA;
      Rready     <= 1'b0;
      ld_off     <= '0;
      ld_size    <= SZ_BYTE;
      ld_signed  <= 1'b0;
    end else begin
      state      <= state_nx;
      aw_done    <= aw_done_nx;
      w_done     <= w_done_nx;
      tmo_flag   <= tmo_flag_nx;
      tmo_cnt    <= (state_nx != state) ? '0 : tmo_cnt + 32'd1;
      req_ready  <= (state_nx == ST_IDLE);
      resp_valid <= (state_nx == ST_RESP);
      resp_rdata <= rdata_nx;
      resp_err   <= err_nx;
      halted     <= halted | (state_nx == ST_HALT);
      AWvalid    <= (state_nx == ST_WR_AW) & ~aw_done_nx;
      Wvalid     <= (state_nx == ST_WR_AW) & ~w_done_nx;
      Bready     <= (state_nx == ST_WR_B);
      ARvalid    <= (state_nx == ST_RD_A);
      Rready     <= (state_nx == ST_RD_D);
      if (accept && !misalign) begin
        ARaddr    <= {req_addr[ADDR_W-1:LGNB], LGNB'(0)};
        AWaddr    <= {req_addr[ADDR_W-1:LGNB], LGNB'(0)};
        ARprot    <= prot_sel;
        AWprot    <= prot_sel;
        Wdata     <= st_wdata_sh;
        Wstrb     <= req_we ? st_strb : '0;
        ld_off    <= req_addr[LGNB-1:0];
        ld_size   <= req_size;
        ld_signed <= req_signed;
      end
    end
  end

endmodule
